// File: rtl/ppu_vram_arb_pkg.sv
// Shared types and constants for the PPU VRAM arbiter.
// Optional feature macro used by the arbiter files: PPU_VRAM_ARB_RAW_FWD_EN.
package ppu_vram_arb_pkg;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam int unsigned VRAM_ADDR_W        = 16;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RENDER,
    SRC_CPU_WR,
    SRC_CPU_RD
  } vram_src_t;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [7:0]             data;
  } vram_wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Circular write queue for CPU->VRAM writes with push/pop/level.
// With PPU_VRAM_ARB_RAW_FWD_EN defined it adds a newest-match address lookup.
module vram_wr_fifo
  import ppu_vram_arb_pkg::*;
#(
  parameter int unsigned Depth = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  vram_wr_entry_t         push_entry,
  input  logic                   pop,
  output vram_wr_entry_t         head,
  output logic [$clog2(Depth):0] level,
  output logic                   empty,
  output logic                   full
`ifdef PPU_VRAM_ARB_RAW_FWD_EN
  ,
  input  logic [VRAM_ADDR_W-1:0] lookup_addr,
  output logic                   lookup_hit,
  output logic [7:0]             lookup_data
`endif
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  vram_wr_entry_t  mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LvlW'(Depth));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

`ifdef PPU_VRAM_ARB_RAW_FWD_EN
  // Scan oldest to newest so the last hit is the newest queued write.
  always_comb begin
    logic [PtrW-1:0] idx;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if ((LvlW'(i) < level_q) && (mem_q[idx].addr == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_q[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Single-port VRAM arbiter: renderer has absolute priority, CPU writes queue and CPU reads
// wait in one pending slot. Define PPU_VRAM_ARB_RAW_FWD_EN to serve reads from queued writes.
module ppu_vram_arbiter
  import ppu_vram_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned ADDR_W     = VRAM_ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        render_req,
  input  logic [ADDR_W-1:0]           render_addr,
  output logic [7:0]                  render_rdata,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [7:0]                  cpu_wdata,
  output logic                        cpu_ready,
  output logic                        cpu_rvalid,
  output logic [7:0]                  cpu_rdata,
  output logic [ADDR_W-1:0]           vram_addr,
  output logic                        vram_we,
  output logic [7:0]                  vram_wdata,
  input  logic [7:0]                  vram_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        err_overflow
);

  vram_src_t      src;
  vram_wr_entry_t fifo_head, push_entry;
  logic           fifo_empty, fifo_full;
  logic           wr_accept, rd_accept, fwd_hit;
  logic           rd_pending_q, rd_tag_q, cpu_rvalid_q, err_overflow_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [7:0]     cpu_rdata_q;
  logic           ret_valid;
  logic [7:0]     ret_data;

  assign cpu_ready       = cpu_we ? !fifo_full : !rd_pending_q;
  assign wr_accept       = cpu_req && cpu_ready && cpu_we;
  assign rd_accept       = cpu_req && cpu_ready && !cpu_we;
  assign push_entry.addr = VRAM_ADDR_W'(cpu_addr);
  assign push_entry.data = cpu_wdata;

`ifdef PPU_VRAM_ARB_RAW_FWD_EN
  logic       lookup_hit;
  logic [7:0] lookup_data;
  logic [1:0] fwd_valid_q;
  logic [7:0] fwd_data1_q, fwd_data2_q;

  assign fwd_hit = rd_accept && lookup_hit;

  // Two stages so a forwarded read returns with the same latency as a VRAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_valid_q <= '0;
      fwd_data1_q <= '0;
      fwd_data2_q <= '0;
    end else begin
      fwd_valid_q <= {fwd_valid_q[0], fwd_hit};
      if (fwd_hit) fwd_data1_q <= lookup_data;
      fwd_data2_q <= fwd_data1_q;
    end
  end
`else
  assign fwd_hit = 1'b0;
`endif

  vram_wr_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_wr_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (wr_accept),
    .push_entry (push_entry),
    .pop        (src == SRC_CPU_WR),
    .head       (fifo_head),
    .level      (fifo_level),
    .empty      (fifo_empty),
    .full       (fifo_full)
`ifdef PPU_VRAM_ARB_RAW_FWD_EN
    ,
    .lookup_addr(VRAM_ADDR_W'(cpu_addr)),
    .lookup_hit (lookup_hit),
    .lookup_data(lookup_data)
`endif
  );

  // Pending read is checked after the FIFO so reads never overtake queued writes.
  always_comb begin
    if (render_req) begin
      src = SRC_RENDER;
    end else if (!fifo_empty) begin
      src = SRC_CPU_WR;
    end else if (rd_pending_q) begin
      src = SRC_CPU_RD;
    end else begin
      src = SRC_NONE;
    end
  end

  always_comb begin
    vram_addr  = render_addr;
    vram_we    = 1'b0;
    vram_wdata = '0;
    unique case (src)
      SRC_CPU_WR: begin
        vram_addr  = ADDR_W'(fifo_head.addr);
        vram_we    = 1'b1;
        vram_wdata = fifo_head.data;
      end
      SRC_CPU_RD: vram_addr = rd_addr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
    end else if (rd_accept && !fwd_hit) begin
      rd_pending_q <= 1'b1;
      rd_addr_q    <= cpu_addr;
    end else if (src == SRC_CPU_RD) begin
      rd_pending_q <= 1'b0;
    end
  end

  always_comb begin
    ret_valid = rd_tag_q;
    ret_data  = vram_rdata;
`ifdef PPU_VRAM_ARB_RAW_FWD_EN
    if (fwd_valid_q[1]) begin
      ret_valid = 1'b1;
      ret_data  = fwd_data2_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_tag_q       <= 1'b0;
      cpu_rvalid_q   <= 1'b0;
      cpu_rdata_q    <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      rd_tag_q     <= (src == SRC_CPU_RD);
      cpu_rvalid_q <= ret_valid;
      if (ret_valid) cpu_rdata_q <= ret_data;
      if (cpu_req && !cpu_ready) err_overflow_q <= 1'b1;
    end
  end

  assign render_rdata = vram_rdata;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Self-checking bench for ppu_vram_arbiter with a behavioural synchronous VRAM.
// The forwarding scenario is compiled only when PPU_VRAM_ARB_RAW_FWD_EN is defined.
module tb_ppu_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        render_req;
  logic [15:0] render_addr;
  logic [7:0]  render_rdata;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;
  logic [2:0]  fifo_level;
  logic        err_overflow;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc;

  logic [7:0]  mem    [65536];
  logic [7:0]  shadow [65536];
  logic [23:0] wr_q [$];
  logic [7:0]  rd_q [$];
  logic [23:0] exp_w;
  logic [7:0]  exp_r;

  ppu_vram_arbiter #(
    .FIFO_DEPTH(4),
    .ADDR_W    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .render_req  (render_req),
    .render_addr (render_addr),
    .render_rdata(render_rdata),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .vram_addr   (vram_addr),
    .vram_we     (vram_we),
    .vram_wdata  (vram_wdata),
    .vram_rdata  (vram_rdata),
    .fifo_level  (fifo_level),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous VRAM: data appears the cycle after the address.
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  // Scoreboard: writes and read returns are popped when the DUT produces them.
  always @(negedge clk) begin
    if (!reset) begin
      if (render_req) begin
        n_chk++;
        if (vram_we !== 1'b0 || vram_addr !== render_addr) begin
          n_err++;
          $display("FAIL render_pass: got addr=%h we=%b, need addr=%h we=0",
                   vram_addr, vram_we, render_addr);
        end
      end
      if (vram_we === 1'b1) begin
        n_chk++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL vram_write: got unexpected write %h<-%h, need none", vram_addr, vram_wdata);
        end else begin
          exp_w = wr_q.pop_front();
          if ({vram_addr, vram_wdata} !== exp_w) begin
            n_err++;
            $display("FAIL vram_write: got %h<-%h, need %h<-%h",
                     vram_addr, vram_wdata, exp_w[23:8], exp_w[7:0]);
          end
        end
      end
      if (cpu_rvalid === 1'b1) begin
        n_chk++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL cpu_read: got unexpected rvalid data=%h, need none", cpu_rdata);
        end else begin
          exp_r = rd_q.pop_front();
          if (cpu_rdata !== exp_r) begin
            n_err++;
            $display("FAIL cpu_read: got %h, need %h", cpu_rdata, exp_r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one CPU access for one cycle; expectations are queued only if accepted.
  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] data,
                            output logic accepted);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    @(negedge clk);
    accepted = cpu_ready;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    acc_cyc = cyc;
    if (accepted) begin
      if (we) begin
        wr_q.push_back({addr, data});
        shadow[addr] = data;
      end else begin
        rd_q.push_back(shadow[addr]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (fifo_level !== 3'd0 || vram_we !== 1'b0 || vram_addr !== render_addr) begin
      n_err++;
      $display("FAIL reset_vram: got level=%0d we=%b addr=%h, need 0 0 %h",
               fifo_level, vram_we, vram_addr, render_addr);
    end
    n_chk++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00 || err_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_cpu: got rvalid=%b rdata=%h err=%b, need 0 00 0",
               cpu_rvalid, cpu_rdata, err_overflow);
    end
    for (int w = 0; w < 2; w++) begin
      cpu_we = w[0];
      #1;
      n_chk++;
      if (cpu_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready: we=%0d got %b, need 1", w, cpu_ready);
      end
    end
    cpu_we = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read_idle();
    logic acc;
    int   lat;
    cpu_access(1'b1, 16'h2000, 8'h5A, acc);
    n_chk++;
    if (acc !== 1'b1) begin
      n_err++;
      $display("FAIL idle_wr_accept: got %b, need 1", acc);
    end
    @(negedge clk);
    n_chk++;
    if (vram_we !== 1'b1 || vram_addr !== 16'h2000) begin
      n_err++;
      $display("FAIL idle_wr_slot: got we=%b addr=%h, need 1 2000", vram_we, vram_addr);
    end
    tick();
    cpu_access(1'b0, 16'h2000, 8'h00, acc);
    lat = -1;
    for (int k = 0; k < 12 && lat < 0; k++) begin
      @(negedge clk);
      if (cpu_rvalid === 1'b1) lat = cyc - acc_cyc;
      tick();
    end
    n_chk++;
    if (lat != 2) begin
      n_err++;
      $display("FAIL idle_rd_latency: got %0d edges, need 2", lat);
    end
  endtask

  task automatic test_overflow_render();
    logic acc;
    render_req  = 1'b1;
    render_addr = 16'h0440;
    for (int i = 0; i < 4; i++) begin
      cpu_access(1'b1, 16'h2100 + 16'(i), 8'hC0 + 8'(i), acc);
      n_chk++;
      if (acc !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_push%0d: got accept=%b, need 1", i, acc);
      end
    end
    @(negedge clk);
    n_chk++;
    if (fifo_level !== 3'd4) begin
      n_err++;
      $display("FAIL ovf_level_full: got %0d, need 4", fifo_level);
    end
    tick();
    cpu_access(1'b1, 16'h21FF, 8'hEE, acc);
    n_chk++;
    if (acc !== 1'b0 || err_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_fifth: got ready=%b err=%b, need 0 1", acc, err_overflow);
    end
    repeat (3) tick();
    render_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (fifo_level !== 3'(4 - k) || vram_we !== (k < 4)) begin
        n_err++;
        $display("FAIL ovf_drain%0d: got level=%0d we=%b, need %0d %b",
                 k, fifo_level, vram_we, 4 - k, k < 4);
      end
      tick();
    end
  endtask

  task automatic test_read_behind_writes();
    logic acc;
    int   lat;
    render_req  = 1'b1;
    render_addr = 16'h0500;
    for (int i = 0; i < 3; i++) cpu_access(1'b1, 16'h3000 + 16'(i), 8'h30 + 8'(i), acc);
    @(negedge clk);
    n_chk++;
    if (fifo_level !== 3'd3) begin
      n_err++;
      $display("FAIL rbw_level: got %0d, need 3", fifo_level);
    end
    tick();
    cpu_access(1'b0, 16'h3100, 8'h00, acc);
    render_req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        n_chk++;
        if (vram_we !== 1'b1) begin
          n_err++;
          $display("FAIL rbw_write%0d: got we=%b, need 1", k, vram_we);
        end
      end else if (k == 4) begin
        n_chk++;
        if (vram_we !== 1'b0 || vram_addr !== 16'h3100) begin
          n_err++;
          $display("FAIL rbw_issue: got we=%b addr=%h, need 0 3100", vram_we, vram_addr);
        end
      end
      if (cpu_rvalid === 1'b1) lat = cyc - acc_cyc;
      tick();
    end
    n_chk++;
    if (lat != 5) begin
      n_err++;
      $display("FAIL rbw_latency: got %0d edges, need 5", lat);
    end
  endtask

  task automatic test_render_alternate();
    logic        acc, issued, prev_req;
    logic [15:0] prev_addr;
    int          lat;
    render_req  = 1'b1;
    render_addr = 16'h0800;
    cpu_access(1'b0, 16'h1234, 8'h00, acc);
    issued   = 1'b0;
    lat      = -1;
    prev_req = 1'b1;
    prev_addr = render_addr;
    for (int k = 1; k <= 10; k++) begin
      render_req  = k[0];
      render_addr = 16'h0800 + 16'(k);
      @(negedge clk);
      if (!render_req) begin
        n_chk++;
        if (!issued) begin
          issued = 1'b1;
          if (vram_addr !== 16'h1234 || vram_we !== 1'b0) begin
            n_err++;
            $display("FAIL alt_issue: got addr=%h we=%b, need 1234 0", vram_addr, vram_we);
          end
        end else if (vram_addr !== render_addr) begin
          n_err++;
          $display("FAIL alt_idle: got addr=%h, need %h", vram_addr, render_addr);
        end
      end
      if (prev_req) begin
        n_chk++;
        if (render_rdata !== shadow[prev_addr]) begin
          n_err++;
          $display("FAIL alt_rdata: got %h, need %h", render_rdata, shadow[prev_addr]);
        end
      end
      if (k == 1 || k == 3) begin
        n_chk++;
        if (cpu_ready !== (k == 3)) begin
          n_err++;
          $display("FAIL alt_ready%0d: got %b, need %b", k, cpu_ready, k == 3);
        end
      end
      if (cpu_rvalid === 1'b1 && lat < 0) lat = cyc - acc_cyc;
      prev_req  = render_req;
      prev_addr = render_addr;
      tick();
    end
    render_req = 1'b0;
    n_chk++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL alt_latency: got %0d edges, need 3", lat);
    end
  endtask

`ifdef PPU_VRAM_ARB_RAW_FWD_EN
  task automatic test_raw_forward();
    logic acc;
    int   lat;
    render_req  = 1'b1;
    render_addr = 16'h0900;
    cpu_access(1'b1, 16'h23C0, 8'h11, acc);
    cpu_access(1'b0, 16'h23C0, 8'h00, acc);
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_chk++;
        if (cpu_ready !== 1'b1 || fifo_level !== 3'd1) begin
          n_err++;
          $display("FAIL fwd_state: got ready=%b level=%0d, need 1 1", cpu_ready, fifo_level);
        end
      end
      if (cpu_rvalid === 1'b1 && lat < 0) lat = cyc - acc_cyc;
      tick();
    end
    n_chk++;
    if (lat != 2) begin
      n_err++;
      $display("FAIL fwd_latency: got %0d edges, need 2", lat);
    end
    render_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (vram_we !== 1'b1 || vram_addr !== 16'h23C0) begin
      n_err++;
      $display("FAIL fwd_drain: got we=%b addr=%h, need 1 23c0", vram_we, vram_addr);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (vram_we !== 1'b0 || vram_addr !== render_addr) begin
      n_err++;
      $display("FAIL fwd_no_read: got we=%b addr=%h, need 0 %h", vram_we, vram_addr, render_addr);
    end
    tick();
  endtask
`endif

  task automatic test_reset_midop();
    logic acc;
    n_chk++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_err++;
      $display("FAIL drained: got %0d writes %0d reads outstanding, need 0 0",
               wr_q.size(), rd_q.size());
    end
    render_req  = 1'b1;
    render_addr = 16'h0A00;
    cpu_access(1'b1, 16'h3200, 8'h77, acc);
    cpu_access(1'b1, 16'h3201, 8'h78, acc);
    cpu_access(1'b0, 16'h3300, 8'h00, acc);
    #2 reset = 1'b1;
    wr_q.delete();
    rd_q.delete();
    #1;
    n_chk++;
    if (fifo_level !== 3'd0 || vram_we !== 1'b0 || cpu_rvalid !== 1'b0
        || vram_addr !== render_addr) begin
      n_err++;
      $display("FAIL midrst_state: got level=%0d we=%b rvalid=%b addr=%h, need 0 0 0 %h",
               fifo_level, vram_we, cpu_rvalid, vram_addr, render_addr);
    end
    for (int w = 0; w < 2; w++) begin
      cpu_we = w[0];
      #1;
      n_chk++;
      if (cpu_ready !== 1'b1) begin
        n_err++;
        $display("FAIL midrst_ready: we=%0d got %b, need 1", w, cpu_ready);
      end
    end
    render_req = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 65536; i++) shadow[i] = mem[i];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_chk++;
      if (vram_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_quiet%0d: got we=%b rvalid=%b, need 0 0", k, vram_we, cpu_rvalid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = 8'(i ^ (i >> 8) ^ 8'hA5);
      shadow[i] = mem[i];
    end
    reset       = 1'b1;
    render_req  = 1'b0;
    render_addr = 16'h0100;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    test_reset();
    test_write_read_idle();
    test_overflow_render();
    test_read_behind_writes();
    test_render_alternate();
`ifdef PPU_VRAM_ARB_RAW_FWD_EN
    test_raw_forward();
`endif
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ppu_vram_arbiter.md
# ppu_vram_arbiter

Shares the single-port synchronous VRAM between the PPU renderer and the CPU-facing PPU register port. The renderer has absolute priority every cycle, because pixel fetch is real-time. CPU writes are queued in a small FIFO and CPU reads are held in a single pending slot; both drain into idle VRAM cycles, so CPU access is no longer restricted to vblank. The block sits between `ppu_render`, `ppu_reg` and `VRAM`, replacing the vblank-based address mux in the PPU top level.

## Interface
- `FIFO_DEPTH`, 4: CPU write queue entries (power of 2, ≥2).
- `ADDR_W`, 16: VRAM address width.
- `clk` in 1: PPU clock.
- `reset` in 1: asynchronous, active-high.
- `render_req` in 1: renderer wants VRAM this cycle.
- `render_addr` in ADDR_W: renderer read address.
- `render_rdata` out 8: combinational copy of `vram_rdata`.
- `cpu_req` in 1: CPU-side access request, single cycle per access.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU-side address.
- `cpu_wdata` in 8: write data.
- `cpu_ready` out 1: combinational. When `cpu_we` = 1, it equals !fifo_full. When `cpu_we` = 0, it equals !rd_pending.
- `cpu_rvalid` out 1: one-cycle pulse, read data valid.
- `cpu_rdata` out 8: registered read data.
- `vram_addr` out ADDR_W: to VRAM.
- `vram_we` out 1: to VRAM.
- `vram_wdata` out 8: to VRAM.
- `vram_rdata` in 8: from VRAM, valid the cycle after the address.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: queued write count.
- `err_overflow` out 1: sticky. Set by `cpu_req` while `cpu_ready` = 0; cleared only by reset.

## Operation
- Accept: the request is accepted on an edge where `cpu_req` && `cpu_ready`.
  - Accepted write: pushes {addr, data} into the FIFO.
  - Accepted read: loads the pending-read register (addr, rd_pending = 1).
  - A request with `cpu_ready` = 0 is dropped, with no state change except `err_overflow`.
- Slot selection each cycle, in priority order:
  - SRC_RENDER if `render_req`. `vram_addr` = `render_addr`, `vram_we` = 0.
  - Else SRC_CPU_WR if the FIFO is non-empty. Drive the FIFO head, `vram_we` = 1, pop at the edge.
  - Else SRC_CPU_RD if rd_pending. Drive the pending address, `vram_we` = 0; rd_pending clears at the edge.
  - Else SRC_NONE. `vram_addr` = `render_addr`, `vram_we` = 0.
- Ordering:
  - A pending read never issues while the FIFO is non-empty (read-after-write order).
  - Writes drain in acceptance order.
- Read return:
  - A one-bit tag registers SRC_CPU_RD at the issue edge.
  - On the following edge, `cpu_rdata` <= `vram_rdata` and `cpu_rvalid` <= 1 for one cycle.
- Push and pop may occur on the same edge; the level is then unchanged. A push into a full FIFO is impossible because `cpu_ready` = 0.
- FIFO pointers wrap modulo FIFO_DEPTH. Full = level == FIFO_DEPTH.
- Reset, asynchronous, may arrive mid-operation:
  - FIFO flushed, pending read dropped, tag cleared, no `cpu_rvalid`.
  - `cpu_rdata` = 0, `err_overflow` = 0, `fifo_level` = 0.
  - Combinational outputs from reset state: `vram_we` = 0, `vram_addr` = `render_addr`, `cpu_ready` = 1.

## Timing
- Renderer: zero added latency. Address passes combinationally and `render_rdata` is valid one cycle after `render_req`, exactly as a direct VRAM connection.
- CPU write: earliest VRAM write in the cycle after accept. Under continuous `render_req` it waits indefinitely; the renderer is never stalled.
- CPU read:
  - Minimum latency: accept on edge N, issue during cycle N→N+1, RAM output N+1→N+2, `cpu_rdata`/`cpu_rvalid` high during cycle N+2→N+3.
  - Each cycle of renderer occupancy or each queued write ahead of the read adds one cycle.
- `cpu_ready` for reads returns to 1 in the cycle after the read issues, so a new read may be accepted while the previous one's data is still in flight.

## Configuration
- `PPU_VRAM_ARB_RAW_FWD_EN`:
  - Defined: an accepted read whose address matches any queued FIFO entry is served from the newest matching entry, with no VRAM access. It keeps the same 2-edge latency as an unqueued read, rd_pending is never set, and older writes keep draining.
  - Undefined: reads always wait for FIFO drain, as described in Operation.

## Structure
- Package `ppu_vram_arb_pkg` holds:
  - enum `vram_src_t` {SRC_NONE, SRC_RENDER, SRC_CPU_WR, SRC_CPU_RD};
  - struct `vram_wr_entry_t` {addr[ADDR_W], data[8]};
  - default-depth constant.
- Sub-module `vram_wr_fifo`: registered circular buffer with push/pop/level. When `PPU_VRAM_ARB_RAW_FWD_EN` is defined, it also has a combinational newest-match lookup port.

## Test plan
- Idle renderer: write 0x2000←0x5A, then read 0x2000 → `vram_we` pulse at addr 0x2000 in the cycle after accept; `cpu_rvalid` with 0x5A exactly 2 edges after read accept (without FWD it follows the drain).
- `render_req` held for 10 cycles; push 4 writes, then attempt a 5th → `cpu_ready` = 0, `err_overflow` = 1, no VRAM write during render; after release, 4 writes in order on consecutive cycles, `fifo_level` 4→0.
- Read queued behind 3 writes to other addresses, renderer idle → read issues in the 4th cycle after writes start; `cpu_rvalid` 5 edges after read accept.
- `render_req` alternating 1/0 with a pending read → read issues only in a `render_req` = 0 cycle; renderer addresses never delayed.
- Reset asserted asynchronously with 2 queued writes and a read pending → no further `vram_we`, no `cpu_rvalid`, `fifo_level` = 0, `cpu_ready` = 1 immediately.
- With FWD: write 0x23C0←0x11 under continuous render, then read 0x23C0 → `cpu_rvalid` with 0x11 2 edges after accept, no VRAM read issued.
